modbus_tx_frame_ctrl: RTL and testbench

//  Sequencer/arbiter for the UART TX path: takes 7-byte Modbus frames from two requesters
//  (round-robin) and feeds them byte by byte to the TX byte engine, which contains the

---
 rtl/modbus_tx_frame_ctrl.sv | 95 +++++++++
 tb/tb_modbus_tx_frame_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/modbus_tx_frame_ctrl.sv
// modbus_tx_frame_ctrl: round-robin 7-byte Modbus frame sequencer for the UART TX byte engine with 3.5-char silence
// Define MODBUS_CRC_EN to overwrite bytes 5/6 with a bit-serial CRC-16/Modbus of bytes 0..4 before sending.
module modbus_tx_frame_ctrl #(
  parameter int BIT_CLKS = 5208,
  parameter int GAP_BITS = 39
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Req0,
  input  logic [55:0] Frame0,
  input  logic        Req1,
  input  logic [55:0] Frame1,
  output logic        Ack0,
  output logic        Ack1,
  output logic        TX_En,
  output logic [7:0]  TX_Data,
  input  logic        TX_Done_Sig,
  output logic        Busy,
  output logic        Frame_Done
);
  localparam int GAP_CLKS = BIT_CLKS * GAP_BITS;
  localparam int GW = GAP_CLKS > 1 ? $clog2(GAP_CLKS) : 1;
`ifdef MODBUS_CRC_EN
  typedef enum logic [2:0] {IDLE, CRC, SEND, NEXT, GAP} state_t;
  localparam state_t FIRST = CRC;
`else
  typedef enum logic [2:0] {IDLE, SEND, NEXT, GAP} state_t;
  localparam state_t FIRST = SEND;
`endif
  state_t state, state_n;
  logic [55:0] shadow;
  logic [2:0] idx;
  logic ptr, sel, grant, gap_end;
  logic [GW-1:0] gap_cnt;
`ifdef MODBUS_CRC_EN
  logic [5:0] crc_cnt, crc_pos;
  logic [15:0] crc;
  logic crc_fb;
  // bytes 0..4 in send order, each LSB first
  assign crc_pos = 6'd48 - {crc_cnt[5:3], 3'b000} + {3'b000, crc_cnt[2:0]};
  assign crc_fb = crc[0] ^ shadow[crc_pos];
`endif
  always_comb begin
    sel = Req0 & Req1 ? ptr : Req1;
    grant = state == IDLE && (Req0 | Req1) && !RST;
    gap_end = state == GAP && gap_cnt == GW'(GAP_CLKS - 1);
    Ack0 = grant && !sel;
    Ack1 = grant && sel;
    Frame_Done = gap_end && !RST;
    TX_En = state == SEND;
    TX_Data = TX_En ? shadow[6'd48 - {idx, 3'b000} +: 8] : 8'd0;
    state_n = state;
    case (state)
      IDLE: state_n = Req0 | Req1 ? FIRST : IDLE;
`ifdef MODBUS_CRC_EN
      CRC:  state_n = crc_cnt == 6'd40 ? SEND : CRC;
`endif
      SEND: state_n = TX_Done_Sig ? (idx == 3'd6 ? GAP : NEXT) : SEND;
      NEXT: state_n = SEND;
      GAP:  state_n = gap_end ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      shadow <= '0;
      idx <= '0;
      ptr <= 1'b0;
      gap_cnt <= '0;
      Busy <= 1'b0;
`ifdef MODBUS_CRC_EN
      crc_cnt <= '0;
      crc <= 16'hFFFF;
`endif
    end else begin
      state <= state_n;
      if (grant) begin
        shadow <= sel ? Frame1 : Frame0;
        ptr <= ~sel;
        idx <= '0;
        Busy <= 1'b1;
      end
      if (state == NEXT) idx <= idx + 3'd1;
      gap_cnt <= state == GAP && !gap_end ? gap_cnt + GW'(1) : '0;
      if (gap_end) Busy <= 1'b0;
`ifdef MODBUS_CRC_EN
      crc_cnt <= state == CRC ? crc_cnt + 6'd1 : 6'd0;
      if (grant) crc <= 16'hFFFF;
      else if (state == CRC && crc_cnt != 6'd40) crc <= {1'b0, crc[15:1]} ^ (crc_fb ? 16'hA001 : 16'h0000);
      if (state == CRC && crc_cnt == 6'd40) shadow[15:0] <= {crc[7:0], crc[15:8]};
`endif
    end
  end
endmodule

// File: tb/tb_modbus_tx_frame_ctrl.sv
// tb_modbus_tx_frame_ctrl: scoreboard bench for modbus_tx_frame_ctrl with BIT_CLKS=8, GAP_BITS=4
// Define MODBUS_CRC_EN for the CRC build; expected bytes 5/6 then come from the CRC-16/Modbus model.
module tb_modbus_tx_frame_ctrl;
  logic CLK = 0, RST = 1, Req0 = 0, Req1 = 0, eng_done = 0, spur = 0, prev_en = 0;
  logic TX_Done_Sig, Ack0, Ack1, TX_En, Busy, Frame_Done;
  logic [55:0] Frame0 = '0, Frame1 = '0, cur = '0;
  logic [7:0] TX_Data;
  logic [55:0] f0q[$], f1q[$], ef[$];
  logic eg[$];
  int total = 0, bad = 0, cyc = 0, eng_cnt = 0, bcnt = 0, low_cnt = 0, last_done = 0, ack_cyc = 0, acks = 0, fd_cnt = 0;
`ifdef MODBUS_CRC_EN
  localparam int LAT = 42;
`else
  localparam int LAT = 1;
`endif
  assign TX_Done_Sig = eng_done | spur;
  modbus_tx_frame_ctrl #(.BIT_CLKS(8), .GAP_BITS(4)) dut (
    .CLK(CLK), .RST(RST), .Req0(Req0), .Frame0(Frame0), .Req1(Req1), .Frame1(Frame1),
    .Ack0(Ack0), .Ack1(Ack1), .TX_En(TX_En), .TX_Data(TX_Data), .TX_Done_Sig(TX_Done_Sig),
    .Busy(Busy), .Frame_Done(Frame_Done)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", n, a, e, cyc);
    end
  endtask
  function automatic logic [55:0] expf(input logic [55:0] f);
`ifdef MODBUS_CRC_EN
    logic [15:0] c = 16'hFFFF;
    for (int k = 0; k < 5; k++) begin
      c ^= {8'h00, f[8*(6-k) +: 8]};
      for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 16'hA001 : c >> 1;
    end
    return {f[55:16], c[7:0], c[15:8]};
`else
    return f;
`endif
  endfunction
  task automatic issue(input logic r, input logic [55:0] f);
    if (r) f1q.push_back(f);
    else f0q.push_back(f);
    eg.push_back(r);
    ef.push_back(expf(f));
  endtask
  task automatic wait_ack(input int n);
    int t = acks + n;
    for (int i = 0; i < 3000 && acks < t; i++) @(posedge CLK);
    if (acks < t) chk("timeout_ack", 64'(acks), 64'(t));
  endtask
  task automatic wait_bytes(input int n);
    for (int i = 0; i < 2000 && bcnt < n; i++) @(posedge CLK);
    if (bcnt < n) chk("timeout_bytes", 64'(bcnt), 64'(n));
  endtask
  task automatic wait_fd(input int n);
    int t = fd_cnt + n;
    for (int i = 0; i < 3000 * n && fd_cnt < t; i++) @(posedge CLK);
    if (fd_cnt < t) chk("timeout_frame_done", 64'(fd_cnt), 64'(t));
  endtask
  initial forever begin
    @(posedge CLK);
    cyc++;
  end
  // TX byte engine model: Done 80 cycles after TX_En rises
  initial forever begin
    @(negedge CLK);
    eng_cnt = TX_En ? eng_cnt + 1 : 0;
    eng_done = eng_cnt == 80;
  end
  initial forever begin
    @(posedge CLK);
    #1;
    Req0 = f0q.size() != 0;
    Frame0 = Req0 ? f0q[0] : 56'h0;
    Req1 = f1q.size() != 0;
    Frame1 = Req1 ? f1q[0] : 56'h0;
  end
  initial forever begin
    @(negedge CLK);
    if (Ack0 && f0q.size() != 0) void'(f0q.pop_front());
    if (Ack1 && f1q.size() != 0) void'(f1q.pop_front());
  end
  initial forever begin
    @(negedge CLK);
    if (RST) begin
      bcnt = 0;
      low_cnt = 0;
    end else begin
      if (Ack0 | Ack1) begin
        chk("ack_both", 64'(Ack0 & Ack1), 64'(0));
        chk("ack_busy", 64'(Busy), 64'(0));
        if (eg.size() == 0) begin
          total++;
          bad++;
          $display("FAIL grant_unexpected actual=%0d required=none", Ack1);
        end else chk("grant", 64'(Ack1), 64'(eg.pop_front()));
        ack_cyc = cyc;
        bcnt = 0;
        acks++;
      end
      if (TX_En && !prev_en) begin
        if (bcnt == 0) begin
          chk("first_latency", 64'(cyc - ack_cyc), 64'(LAT));
          if (ef.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame_unexpected actual=%0h required=none", TX_Data);
          end else cur = ef.pop_front();
        end else chk("byte_gap", 64'(low_cnt), 64'(1));
        chk("byte", 64'(TX_Data), 64'(cur[8*(6-bcnt) +: 8]));
        chk("busy_send", 64'(Busy), 64'(1));
      end
      if (TX_En && TX_Done_Sig) begin
        bcnt++;
        last_done = cyc;
      end
      low_cnt = TX_En ? 0 : low_cnt + 1;
      if (Frame_Done) begin
        chk("done_gap", 64'(cyc - last_done), 64'(32));
        chk("done_bytes", 64'(bcnt), 64'(7));
        fd_cnt++;
      end
    end
    prev_en = TX_En;
  end
  initial begin
    #800000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(posedge CLK);
    #1 RST = 0;
    @(negedge CLK);
    chk("rst_ack0", 64'(Ack0), 64'(0));
    chk("rst_ack1", 64'(Ack1), 64'(0));
    chk("rst_tx_en", 64'(TX_En), 64'(0));
    chk("rst_tx_data", 64'(TX_Data), 64'(0));
    chk("rst_busy", 64'(Busy), 64'(0));
    chk("rst_frame_done", 64'(Frame_Done), 64'(0));
    issue(0, 56'h01_03_00_6B_00_03_AA);
    wait_ack(1);
    wait_bytes(7);
    repeat (5) @(posedge CLK);
    #1 spur = 1;
    @(posedge CLK);
    #1 spur = 0;
    wait_fd(1);
    repeat (3) @(posedge CLK);
    #1 spur = 1;
    @(posedge CLK);
    #1 spur = 0;
    @(negedge CLK);
    chk("idle_spur_busy", 64'(Busy), 64'(0));
    chk("idle_spur_tx_en", 64'(TX_En), 64'(0));
    issue(0, 56'h11_22_33_44_55_66_77);
    wait_ack(1);
    wait_bytes(2);
    issue(1, 56'hA1_B2_C3_D4_E5_F6_07);
    wait_fd(1);
    @(negedge CLK);
    chk("ack1_first_idle", 64'(Ack1), 64'(1));
    wait_fd(1);
    issue(0, 56'h0A_0B_0C_0D_0E_0F_10);
    issue(1, 56'h1A_1B_1C_1D_1E_1F_20);
    issue(0, 56'h2A_2B_2C_2D_2E_2F_30);
    wait_fd(3);
    issue(0, 56'hFE_DC_BA_98_76_54_32);
    wait_ack(1);
    wait_bytes(3);
    repeat (20) @(posedge CLK);
    #1 RST = 1;
    @(posedge CLK);
    #1 RST = 0;
    @(negedge CLK);
    chk("abort_tx_en", 64'(TX_En), 64'(0));
    chk("abort_busy", 64'(Busy), 64'(0));
    chk("abort_tx_data", 64'(TX_Data), 64'(0));
    ef.delete();
    issue(0, 56'h5A_A5_3C_C3_0F_F0_99);
    wait_fd(1);
    issue(0, 56'h01_06_00_01_00_00_00);
    wait_fd(1);
    repeat (5) @(posedge CLK);
    chk("queues_drained", 64'(ef.size() + eg.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
